// File: rtl/bus_if_ctrl.sv
`default_nettype none
// ============================================================================
// Module : bus_if_ctrl
// Routes one MEM-stage access to the scratch-pad memory or the arbitrated bus.
// Rev    : 1.0
// ============================================================================
module bus_if_ctrl #(
  parameter logic [2:0]  SPM_TAG = 3'b000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        stall,
  input  logic        flush,
  output logic        busy,
  input  logic [29:0] addr,
  input  logic        as_,
  input  logic        rw,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        bus_err,
  output logic [29:0] spm_addr,
  output logic        spm_as_,
  output logic        spm_rw,
  output logic [31:0] spm_wr_data,
  input  logic [31:0] spm_rd_data,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_
);

  localparam logic       c_READ      = 1'b1;
  localparam logic [7:0] c_TMO_LAST  = 8'(TIMEOUT - 1);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_REQ    = 2'd1;
  localparam logic [1:0] c_ST_ACCESS = 2'd2;
  localparam logic [1:0] c_ST_STALL  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        r_bus_req_;
  logic        r_bus_as_;
  logic        r_bus_rw;
  logic [29:0] r_bus_addr;
  logic [31:0] r_bus_wr_data;
  logic [31:0] r_rd_buf;
  logic [7:0]  r_tmo_cnt;
  logic        r_bus_err;

  logic        w_spm_hit;
  logic        w_req;
  logic        w_tmo;
  logic [31:0] w_bus_rd;

  assign w_spm_hit = (addr[29:27] == SPM_TAG);
  assign w_req     = !as_ && !flush;
  assign w_tmo     = (r_tmo_cnt == c_TMO_LAST);
  // Writes return zero to the pipeline so a stale load value never leaks through.
  assign w_bus_rd  = (r_bus_rw == c_READ) ? bus_rd_data : 32'h0;

  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;
  assign bus_req_    = r_bus_req_;
  assign bus_as_     = r_bus_as_;
  assign bus_rw      = r_bus_rw;
  assign bus_addr    = r_bus_addr;
  assign bus_wr_data = r_bus_wr_data;
  assign bus_err     = r_bus_err;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) r_state <= c_ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_req && !w_spm_hit) w_next_state = c_ST_REQ;
      c_ST_REQ:    if (!bus_grnt_) w_next_state = c_ST_ACCESS;
      c_ST_ACCESS: begin
        if (!bus_rdy_)  w_next_state = stall ? c_ST_STALL : c_ST_IDLE;
        else if (w_tmo) w_next_state = c_ST_IDLE;
      end
      c_ST_STALL:  if (!stall || flush) w_next_state = c_ST_IDLE;
      default:     w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    rd_data = 32'h0;
    spm_as_ = 1'b1;
    case (r_state)
      c_ST_IDLE: begin
        if (w_req) begin
          if (w_spm_hit) begin
            spm_as_ = stall;
            rd_data = spm_rd_data;
          end else begin
            busy = 1'b1;
          end
        end
      end
      c_ST_REQ:    busy = 1'b1;
      c_ST_ACCESS: begin
        if (!bus_rdy_) rd_data = w_bus_rd;
        else           busy    = 1'b1;
      end
      c_ST_STALL:  rd_data = r_rd_buf;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_bus_req_    <= 1'b1;
      r_bus_as_     <= 1'b1;
      r_bus_rw      <= c_READ;
      r_bus_addr    <= 30'h0;
      r_bus_wr_data <= 32'h0;
      r_rd_buf      <= 32'h0;
      r_tmo_cnt     <= 8'h0;
      r_bus_err     <= 1'b0;
    end else begin
      r_bus_as_ <= 1'b1;
      r_bus_err <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_req && !w_spm_hit) begin
            r_bus_addr    <= addr;
            r_bus_rw      <= rw;
            r_bus_wr_data <= wr_data;
            r_bus_req_    <= 1'b0;
          end
        end
        c_ST_REQ: begin
          if (!bus_grnt_) begin
            r_bus_as_ <= 1'b0;
            r_tmo_cnt <= 8'h0;
          end
        end
        c_ST_ACCESS: begin
          // Ready wins over the timeout on the final permitted cycle.
          if (!bus_rdy_) begin
            r_rd_buf   <= w_bus_rd;
            r_bus_req_ <= 1'b1;
          end else if (w_tmo) begin
            r_bus_err  <= 1'b1;
            r_bus_req_ <= 1'b1;
            r_rd_buf   <= 32'h0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
